// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator: tap positions inside the
// packed window and the width helper used for coordinate counters.
package window_gen_3x3_pkg;

    localparam int WIN_TL   = 0;
    localparam int WIN_TM   = 1;
    localparam int WIN_TR   = 2;
    localparam int WIN_ML   = 3;
    localparam int WIN_C    = 4;
    localparam int WIN_MR   = 5;
    localparam int WIN_BL   = 6;
    localparam int WIN_BM   = 7;
    localparam int WIN_BR   = 8;
    localparam int WIN_TAPS = 9;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int log2_ceil(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of storage: single clock, one read and one write port,
// registered read-first output so it maps onto block RAM.
module window_gen_3x3_line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int  DEPTH = 640,
    parameter int  WIDTH = 8,
    localparam int AW    = log2_ceil(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately never reset; downstream gating hides stale data.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 neighbourhood: two line buffers feed a column
// shift register; one window per interior pixel, two cycles after the pixel.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int  inputWidth = 8,
    parameter int  IMG_WIDTH  = 640,
    parameter int  IMG_HEIGHT = 480,
    localparam int XW         = log2_ceil(IMG_WIDTH),
    localparam int YW         = log2_ceil(IMG_HEIGHT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [inputWidth-1:0]            pixel_in,
    input  logic                             pixel_valid,
    input  logic                             frame_start,
    output logic [WIN_TAPS*inputWidth-1:0]   windowIn_out,
    output logic                             window_valid,
    output logic [XW-1:0]                    center_x,
    output logic [YW-1:0]                    center_y,
    output logic                             frame_done
);

    localparam logic [XW-1:0] COL_LAST      = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST      = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] COL_FIRST_WIN = XW'(2);
    localparam logic [YW-1:0] ROW_FIRST_WIN = YW'(2);

    typedef logic [WIN_TAPS-1:0][inputWidth-1:0] window_t;

    logic [XW-1:0]         col;
    logic [YW-1:0]         row;
    logic [XW-1:0]         cur_col;
    logic [YW-1:0]         cur_row;

    logic                  s1_valid;
    logic [XW-1:0]         s1_col;
    logic [YW-1:0]         s1_row;
    logic [inputWidth-1:0] s1_pix;

    logic [inputWidth-1:0] top_rd;
    logic [inputWidth-1:0] mid_rd;

    window_t               win_sr;
    window_t               win_next;
    window_t               win_out;
    logic                  win_emit;

    // A qualified frame_start pins the accepted pixel to (0,0).
    always_comb begin
        cur_col = frame_start ? '0 : col;
        cur_row = frame_start ? '0 : row;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            s1_valid <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_pix   <= '0;
        end else begin
            s1_valid <= pixel_valid;
            if (pixel_valid) begin
                s1_col <= cur_col;
                s1_row <= cur_row;
                s1_pix <= pixel_in;
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + YW'(1);
                end else begin
                    col <= cur_col + XW'(1);
                    row <= cur_row;
                end
            end
        end
    end

    // lb_mid holds row r-1; lb_top (row r-2) is refilled one cycle later
    // from lb_mid's read-first data at the delayed column address.
    window_gen_3x3_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (inputWidth)
    ) u_lb_mid (
        .clk     (clk),
        .rd_en   (pixel_valid),
        .rd_addr (cur_col),
        .rd_data (mid_rd),
        .wr_en   (pixel_valid),
        .wr_addr (cur_col),
        .wr_data (pixel_in)
    );

    window_gen_3x3_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (inputWidth)
    ) u_lb_top (
        .clk     (clk),
        .rd_en   (pixel_valid),
        .rd_addr (cur_col),
        .rd_data (top_rd),
        .wr_en   (s1_valid),
        .wr_addr (s1_col),
        .wr_data (mid_rd)
    );

    always_comb begin
        win_next         = win_sr;
        win_next[WIN_TL] = win_sr[WIN_TM];
        win_next[WIN_TM] = win_sr[WIN_TR];
        win_next[WIN_TR] = top_rd;
        win_next[WIN_ML] = win_sr[WIN_C];
        win_next[WIN_C]  = win_sr[WIN_MR];
        win_next[WIN_MR] = mid_rd;
        win_next[WIN_BL] = win_sr[WIN_BM];
        win_next[WIN_BM] = win_sr[WIN_BR];
        win_next[WIN_BR] = s1_pix;
    end

    // Columns 0/1 and rows 0/1 only prime the shift register and buffers.
    assign win_emit = s1_valid && (s1_row >= ROW_FIRST_WIN) && (s1_col >= COL_FIRST_WIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_sr       <= '0;
            win_out      <= '0;
            window_valid <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= win_emit;
            frame_done   <= win_emit && (s1_col == COL_LAST) && (s1_row == ROW_LAST);
            if (s1_valid) win_sr <= win_next;
            if (win_emit) begin
                win_out  <= win_next;
                center_x <= s1_col - XW'(1);
                center_y <= s1_row - YW'(1);
            end
        end
    end

    assign windowIn_out = win_out;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x4 image: table-driven ramp frames,
// randomised gappy traffic against a frame-array model, reset and restart cases.
module tb_window_gen_3x3;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        frame_start;
    logic [71:0] windowIn_out;
    logic        window_valid;
    logic [1:0]  center_x;
    logic [1:0]  center_y;
    logic        frame_done;

    window_gen_3x3 #(
        .inputWidth (PW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .windowIn_out (windowIn_out),
        .window_valid (window_valid),
        .center_x     (center_x),
        .center_y     (center_y),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [71:0] win;
        int          cx;
        int          cy;
        logic        fd;
    } exp_t;

    typedef struct {
        logic        v;
        logic        fs;
        logic [7:0]  px;
        logic        wv;
        logic        fd;
        int          cx;
        int          cy;
        logic [71:0] win;
    } vec_t;

    exp_t        exp_q[$];
    logic [7:0]  img [H][W];
    int          m_idx;
    int          cyc;
    int          n_vec;
    int          n_miss;
    logic [71:0] last_win;

    vec_t        tbl[34];
    int          nwin;
    int          first_j;
    logic [71:0] first_win;
    int          first_cx;
    int          first_cy;
    logic [71:0] wtmp;
    int          f, p, r, c;
    logic        rv, rfs;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int fr, input int rr, input int cc);
        logic [7:0] base;
        base = 8'(rr * 16 + cc);
        return (fr != 0) ? (8'hFF - base) : base;
    endfunction

    // Model: linear raster index per frame, image kept as a 2D array.
    task automatic model_reset();
        m_idx    = 0;
        last_win = '0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic fs, input logic [7:0] px);
        exp_t e;
        int   mr, mc;
        if (fs) m_idx = 0;
        mr = m_idx / W;
        mc = m_idx % W;
        img[mr][mc] = px;
        if (mr >= 2 && mc >= 2) begin
            e.due = cyc + 1;
            for (int k = 0; k < 9; k++) e.win[k*8 +: 8] = img[mr - 2 + k / 3][mc - 2 + k % 3];
            e.cx = mc - 1;
            e.cy = mr - 1;
            e.fd = (mr == H - 1) && (mc == W - 1);
            exp_q.push_back(e);
        end
        m_idx = (m_idx + 1) % (W * H);
    endtask

    task automatic model_check();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL late_window: due cycle %0d still pending at cycle %0d", e.due, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("model_valid", 72'(window_valid), 72'(1));
            chk("model_window", windowIn_out, e.win);
            chk("model_center_x", 72'(center_x), 72'(e.cx));
            chk("model_center_y", 72'(center_y), 72'(e.cy));
            chk("model_frame_done", 72'(frame_done), 72'(e.fd));
            last_win = e.win;
        end else begin
            chk("model_valid_idle", 72'(window_valid), 72'(0));
            chk("model_frame_done_idle", 72'(frame_done), 72'(0));
            chk("model_window_hold", windowIn_out, last_win);
        end
    endtask

    task automatic drive(input logic v, input logic fs, input logic [7:0] px);
        pixel_valid = v;
        frame_start = fs;
        pixel_in    = px;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else if (v) model_accept(fs, px);
        #1;
        model_check();
    endtask

    task automatic do_reset(input logic v, input logic [7:0] px);
        rst_n = 1'b0;
        drive(v, 1'b0, px);
        chk("rst_valid", 72'(window_valid), 72'(0));
        chk("rst_window", windowIn_out, 72'(0));
        chk("rst_center_x", 72'(center_x), 72'(0));
        chk("rst_center_y", 72'(center_y), 72'(0));
        chk("rst_frame_done", 72'(frame_done), 72'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        pixel_in    = '0;
        cyc         = 0;
        n_vec       = 0;
        n_miss      = 0;
        m_idx       = 0;
        last_win    = '0;

        // Two ramp frames back to back: r*16+c then 0xFF-(r*16+c).
        for (int i = 0; i < 34; i++) begin
            tbl[i].v   = 1'b0;
            tbl[i].fs  = 1'b0;
            tbl[i].px  = '0;
            tbl[i].wv  = 1'b0;
            tbl[i].fd  = 1'b0;
            tbl[i].cx  = 0;
            tbl[i].cy  = 0;
            tbl[i].win = '0;
            if (i < 32) begin
                f = i / 16;
                p = i % 16;
                tbl[i].v  = 1'b1;
                tbl[i].fs = (p == 0);
                tbl[i].px = pix_val(f, p / 4, p % 4);
            end
            if (i >= 1 && i <= 32) begin
                f = (i - 1) / 16;
                p = (i - 1) % 16;
                r = p / 4;
                c = p % 4;
                if (r >= 2 && c >= 2) begin
                    for (int k = 0; k < 9; k++) wtmp[k*8 +: 8] = pix_val(f, r - 2 + k / 3, c - 2 + k % 3);
                    tbl[i].wv  = 1'b1;
                    tbl[i].cx  = c - 1;
                    tbl[i].cy  = r - 1;
                    tbl[i].fd  = (r == 3) && (c == 3);
                    tbl[i].win = wtmp;
                end
            end
        end

        do_reset(1'b0, 8'h00);
        do_reset(1'b0, 8'h00);

        nwin = 0;
        for (int i = 0; i < 34; i++) begin
            drive(tbl[i].v, tbl[i].fs, tbl[i].px);
            chk("tbl_valid", 72'(window_valid), 72'(tbl[i].wv));
            if (tbl[i].wv) begin
                chk("tbl_window", windowIn_out, tbl[i].win);
                chk("tbl_center_x", 72'(center_x), 72'(tbl[i].cx));
                chk("tbl_center_y", 72'(center_y), 72'(tbl[i].cy));
                chk("tbl_frame_done", 72'(frame_done), 72'(tbl[i].fd));
            end
            if (i >= 1 && i <= 16 && window_valid) nwin++;
            if (i == 11) begin
                chk("first_window", windowIn_out, 72'h222120121110020100);
                chk("first_center_x", 72'(center_x), 72'(1));
                chk("first_center_y", 72'(center_y), 72'(1));
            end
            if (i == 16) begin
                chk("last_window", windowIn_out, 72'h333231232221131211);
                chk("last_frame_done", 72'(frame_done), 72'(1));
            end
            if (i == 27) chk("frame2_first_window", windowIn_out, 72'hDDDEDFEDEEEFFDFEFF);
        end
        chk("frame1_window_count", 72'(nwin), 72'(4));

        // Random traffic, ~50% valid duty, stray and occasional mid-frame frame_start.
        for (int k = 0; k < 700; k++) begin
            rv  = 1'($urandom_range(0, 1));
            rfs = 1'b0;
            if (!rv) rfs = 1'($urandom_range(0, 1));
            else if (m_idx == 0 && $urandom_range(0, 3) != 0) rfs = 1'b1;
            else if ($urandom_range(0, 49) == 0) rfs = 1'b1;
            drive(rv, rfs, 8'($urandom));
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);

        // Reset at row 2 col 1, then a frame without frame_start.
        for (int i = 0; i < 10; i++) drive(1'b1, (i == 0), 8'(8'h30 + i));
        do_reset(1'b1, 8'hEE);
        first_j = -1;
        nwin    = 0;
        for (int j = 0; j < 18; j++) begin
            drive((j < 16), 1'b0, 8'(8'h60 + j));
            if (window_valid) begin
                nwin++;
                if (first_j < 0) begin
                    first_j   = j;
                    first_win = windowIn_out;
                end
            end
        end
        chk("rst_first_window_pos", 72'(first_j), 72'(11));
        chk("rst_first_window", first_win, 72'h6A6968666564626160);
        chk("rst_window_count", 72'(nwin), 72'(4));

        // frame_start asserted at (1,3) of a frame in progress.
        for (int i = 0; i < 7; i++) drive(1'b1, (i == 0), 8'(8'h40 + i));
        first_j  = -1;
        first_cx = 0;
        first_cy = 0;
        for (int j = 0; j < 18; j++) begin
            drive((j < 16), (j == 0), 8'(8'hA0 + j));
            if (window_valid && first_j < 0) begin
                first_j   = j;
                first_win = windowIn_out;
                first_cx  = int'(center_x);
                first_cy  = int'(center_y);
            end
        end
        chk("restart_first_window_pos", 72'(first_j), 72'(11));
        chk("restart_first_window", first_win, 72'hAAA9A8A6A5A4A2A1A0);
        chk("restart_center_x", 72'(first_cx), 72'(1));
        chk("restart_center_y", 72'(first_cy), 72'(1));
        chk("model_queue_drained", 72'(exp_q.size()), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
